// File: rtl/alu_req_scheduler.sv
// Round-robin front end for a bit-serial ALU: two requesters, one transaction in flight.
// Define ALU_REQ_SCHEDULER_TIMEOUT_EN to bound the wait for the first response start bit.
module alu_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_bad_crc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_bad_crc,
  output logic        sin,
  input  logic        sout,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_c,
  output logic [3:0]  resp_flags,
  output logic        resp_err,
  output logic [5:0]  resp_err_flags,
  output logic        resp_timeout
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;
  state_t state, state_nx;

  logic        last_id, cur_id, gnt_valid, gnt_id;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_op;
  logic        sel_bad;
  logic [3:0]  sel_crc;
  logic [98:0] frame, frame_nx;
  logic [6:0]  bit_cnt;
  logic [3:0]  rx_cnt;
  logic [8:0]  rx_sh;
  logic [9:0]  rx_pkt;
  logic [2:0]  pkt_idx;
  logic [31:0] c_acc;
  logic        rx_end, timeout_hit;
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
  logic [31:0] wait_cnt;
`endif

  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ d[67 - i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [10:0] pkt(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  // last_id holds the requester served last; on a tie the other one wins
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_id;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt_id;
  assign req1_ready = ~rst & (state == IDLE) & req1_valid &  gnt_id;

  assign sel_a    = gnt_id ? req1_a : req0_a;
  assign sel_b    = gnt_id ? req1_b : req0_b;
  assign sel_op   = gnt_id ? req1_op : req0_op;
  assign sel_bad  = gnt_id ? req1_bad_crc : req0_bad_crc;
  assign sel_crc  = crc4({sel_b, sel_a, 1'b1, sel_op}) ^ {4{sel_bad}};
  assign frame_nx = {pkt(1'b0, sel_b[31:24]), pkt(1'b0, sel_b[23:16]),
                     pkt(1'b0, sel_b[15:8]),  pkt(1'b0, sel_b[7:0]),
                     pkt(1'b0, sel_a[31:24]), pkt(1'b0, sel_a[23:16]),
                     pkt(1'b0, sel_a[15:8]),  pkt(1'b0, sel_a[7:0]),
                     pkt(1'b1, {1'b0, sel_op, sel_crc})};

  assign sin        = (state == SEND) ? frame[98] : 1'b1;
  assign resp_valid = (state == DONE);

  // rx_pkt = {type, payload[7:0], stop}; the start bit was seen in WAIT
  assign rx_pkt = {rx_sh, sout};
  assign rx_end = (state == RECV) && (rx_cnt == 4'd10);
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
  assign timeout_hit = (state == WAIT) && sout && (pkt_idx == 3'd0) &&
                       (wait_cnt == TIMEOUT_CYCLES - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (gnt_valid) state_nx = SEND;
      SEND: if (bit_cnt == 7'd98) state_nx = WAIT;
      WAIT: begin
        if (!sout)            state_nx = RECV;
        else if (timeout_hit) state_nx = DONE;
      end
      RECV: begin
        if (rx_end) begin
          if (!rx_pkt[0] || (pkt_idx == 3'd0 && rx_pkt[9]) || pkt_idx == 3'd4)
            state_nx = DONE;
          else
            state_nx = WAIT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id        <= 1'b1;
      cur_id         <= 1'b0;
      frame          <= '1;
      bit_cnt        <= '0;
      rx_cnt         <= '0;
      rx_sh          <= '0;
      pkt_idx        <= '0;
      c_acc          <= '0;
      resp_id        <= 1'b0;
      resp_c         <= '0;
      resp_flags     <= '0;
      resp_err       <= 1'b0;
      resp_err_flags <= '0;
      resp_timeout   <= 1'b0;
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            frame   <= frame_nx;
            cur_id  <= gnt_id;
            last_id <= gnt_id;
            bit_cnt <= '0;
            pkt_idx <= '0;
          end
        end
        SEND: begin
          frame   <= {frame[97:0], 1'b1};
          bit_cnt <= bit_cnt + 7'd1;
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          rx_cnt <= 4'd1;
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
          wait_cnt <= wait_cnt + 32'd1;
`endif
          if (sout && timeout_hit) begin
            resp_id        <= cur_id;
            resp_c         <= '0;
            resp_flags     <= '0;
            resp_err       <= 1'b0;
            resp_err_flags <= '0;
            resp_timeout   <= 1'b1;
          end
        end
        RECV: begin
          rx_cnt <= rx_cnt + 4'd1;
          rx_sh  <= {rx_sh[7:0], sout};
          if (rx_end) begin
            if (!rx_pkt[0] || (pkt_idx == 3'd0 && rx_pkt[9])) begin
              resp_id        <= cur_id;
              resp_c         <= '0;
              resp_flags     <= '0;
              resp_err       <= 1'b1;
              resp_err_flags <= !rx_pkt[0] ? 6'h3F : rx_pkt[7:2];
              resp_timeout   <= 1'b0;
            end else if (pkt_idx == 3'd4) begin
              resp_id        <= cur_id;
              resp_c         <= c_acc;
              resp_flags     <= rx_pkt[7:4];
              resp_err       <= 1'b0;
              resp_err_flags <= '0;
              resp_timeout   <= 1'b0;
            end else begin
              c_acc   <= {c_acc[23:0], rx_pkt[8:1]};
              pkt_idx <= pkt_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomized self-checking bench for alu_req_scheduler against a packet-level reference model.
module tb_alu_req_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_bad_crc;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, req1_bad_crc;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        sin, sout;
  logic        resp_valid, resp_id, resp_err, resp_timeout;
  logic [31:0] resp_c;
  logic [3:0]  resp_flags;
  logic [5:0]  resp_err_flags;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        model_last;
  bit          sout_q[$];
  logic [1:0]  v;
  logic        exp_id;
  int          kind, kr;

  always #5 clk = ~clk;

  alu_req_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_bad_crc(req0_bad_crc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_bad_crc(req1_bad_crc),
    .sin(sin), .sout(sout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_c(resp_c), .resp_flags(resp_flags),
    .resp_err(resp_err), .resp_err_flags(resp_err_flags), .resp_timeout(resp_timeout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // CRC as the remainder of message*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [98:0] frame_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic bad);
    logic [98:0] f;
    logic [63:0] ops;
    logic [3:0]  crc;
    f   = '0;
    ops = {b, a};
    for (int k = 0; k < 8; k++) f = {f[87:0], 2'b00, ops[63 - 8*k -: 8], 1'b1};
    crc = crc_model(a, b, op) ^ {4{bad}};
    f   = {f[87:0], 2'b01, 1'b0, op, crc, 1'b1};
    return f;
  endfunction

  task automatic push_pkt(input logic t, input logic [7:0] p, input logic stop);
    repeat ($urandom_range(4, 0)) sout_q.push_back(1'b1);
    sout_q.push_back(1'b0);
    sout_q.push_back(t);
    for (int i = 7; i >= 0; i--) sout_q.push_back(p[i]);
    sout_q.push_back(stop);
  endtask

  // kind: 0 normal, 1 type-1 error, 2 bad stop bit, 3 no response, 4 reset during send
  task automatic run_txn(input logic id, input int kind, input logic [31:0] c_in,
                         input logic [3:0] f_in, input logic [7:0] p_in);
    logic [98:0] exp_f, got_f;
    logic        early, exp_err, exp_to, normal;
    logic [5:0]  exp_ef;
    int unsigned cyc, bad_k;
    #1;
    cyc = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("grant_seen", cyc < 20, 1'b1);
    if (cyc >= 20) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    chk("other_ready", id ? req0_ready : req1_ready, 1'b0);
    exp_f = id ? frame_model(req1_a, req1_b, req1_op, req1_bad_crc)
               : frame_model(req0_a, req0_b, req0_op, req0_bad_crc);
    tick();
    if (id) begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom;
      req1_op = 3'($urandom); req1_bad_crc = ~req1_bad_crc;
    end else begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
      req0_op = 3'($urandom); req0_bad_crc = ~req0_bad_crc;
    end
    for (int i = 0; i < 99; i++) begin
      got_f[98 - i] = sin;
      if (kind == 4 && i == 40) begin
        rst = 1'b1;
        #1;
        chk("rst_sin", sin, 1'b1);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        early = 1'b0;
        repeat (3) begin tick(); early |= resp_valid; end
        rst = 1'b0;
        repeat (5) begin tick(); early |= resp_valid | ~sin; end
        chk("rst_no_resp", early, 1'b0);
        model_last = 1'b1;
        return;
      end
      tick();
    end
    chk(id ? "frame1" : "frame0", got_f, exp_f);
    chk("sin_idle_wait", sin, 1'b1);

    exp_err = 1'b0; exp_to = 1'b0; exp_ef = '0; early = 1'b0;
    normal = (kind == 0);
    case (kind)
      1: begin
        push_pkt(1'b1, p_in, 1'b1);
        exp_err = 1'b1;
        exp_ef  = p_in[6:1];
      end
      2: begin
        bad_k = $urandom_range(4, 0);
        for (int k = 0; k <= int'(bad_k); k++)
          push_pkt(1'(k == 4), 8'($urandom), 1'(k != int'(bad_k)));
        exp_err = 1'b1;
        exp_ef  = 6'h3F;
      end
      3: begin
`ifdef ALU_REQ_SCHEDULER_TIMEOUT_EN
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        chk("timeout_cycles", cyc, 16);
        exp_to = 1'b1;
`else
        repeat (40) begin early |= resp_valid; tick(); end
        normal = 1'b1;
`endif
      end
      default: ;
    endcase
    if (normal) begin
      for (int k = 0; k < 4; k++) push_pkt(1'b0, c_in[31 - 8*k -: 8], 1'b1);
      push_pkt(1'b1, {1'($urandom), f_in, 3'($urandom)}, 1'b1);
    end
    while (sout_q.size() > 0) begin
      early |= resp_valid;
      sout = sout_q.pop_front();
      tick();
    end
    sout = 1'b1;
    chk("resp_valid", resp_valid, 1'b1);
    chk("early_valid", early, 1'b0);
    chk("resp_id", resp_id, id);
    chk("resp_err", resp_err, exp_err);
    chk("resp_timeout", resp_timeout, exp_to);
    if (exp_err) chk("resp_err_flags", resp_err_flags, exp_ef);
    if (normal) begin
      chk("resp_c", resp_c, c_in);
      chk("resp_flags", resp_flags, f_in);
    end
    tick();
    chk("valid_pulse_end", resp_valid, 1'b0);
    chk("resp_id_hold", resp_id, id);
    model_last = id;
  endtask

  initial begin
    rst = 1'b1; sout = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_op = 3'b000; req0_bad_crc = 1'b0;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
    req1_bad_crc = 1'b1;
    model_last = 1'b1;
    repeat (3) tick();
    chk("rst_sin", sin, 1'b1);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_c", resp_c, 32'h0);
    chk("rst_flags", resp_flags, 4'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_err_flags", resp_err_flags, 6'h0);
    chk("rst_timeout", resp_timeout, 1'b0);
    chk("rst_id", resp_id, 1'b0);
    rst = 1'b0;

    // simultaneous requests after reset; req1 carries a corrupted CRC
    run_txn(1'b0, 0, 32'h3, 4'h0, 8'h00);
    run_txn(1'b1, 0, $urandom, 4'($urandom), 8'h00);

    req1_valid = 1'b1;
    run_txn(1'b1, 1, 32'h0, 4'h0, 8'hA4);
    req0_valid = 1'b1;
    run_txn(1'b0, 2, 32'h0, 4'h0, 8'h00);
    req1_valid = 1'b1;
    run_txn(1'b1, 3, $urandom, 4'($urandom), 8'h00);
    req0_valid = 1'b1;
    run_txn(1'b0, 4, 32'h0, 4'h0, 8'h00);
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_txn(1'b0, 0, $urandom, 4'($urandom), 8'h00);
    run_txn(1'b1, 0, $urandom, 4'($urandom), 8'h00);

    for (int n = 0; n < 12; n++) begin
      v = 2'($urandom_range(3, 1));
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom); req0_bad_crc = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom); req1_bad_crc = 1'($urandom);
      req0_valid = v[0]; req1_valid = v[1];
      exp_id = (v == 2'b11) ? ~model_last : v[1];
      kr   = int'($urandom_range(3, 0));
      kind = (kr == 3) ? 2 : (kr == 2) ? 1 : 0;
      run_txn(exp_id, kind, $urandom, 4'($urandom), 8'($urandom));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
